// File: rtl/ioctl_dn_ctrl.sv
// ioctl_dn_ctrl
// Bridges a host ioctl download stream (one byte per ioctl_wr strobe) onto a
// handshaked target write port. It holds the SoC core in reset for the whole
// download window, and for HOLD cycles after the window closes.
//
// Ports
//   clk_sys         sole clock, rising edge
//   reset           synchronous, active-high
//   ioctl_download  host download window active
//   ioctl_wr        single-cycle byte strobe from host
//   ioctl_addr      host byte address (25 bits)
//   ioctl_dout      host byte data
//   ioctl_index     host file/target index
//   ioctl_wait      back-pressure to host, high while the byte buffer is full
//   dn_addr/dn_data target write address/data, stable while dn_wr is high
//   dn_wr           target write request, held until dn_ready
//   dn_ready        target accepts the write when high together with dn_wr
//   dn_index        index latched at download start
//   soc_reset       reset to the SoC core
//   dn_count        bytes accepted by the target in the current/last download
//   dn_err          sticky flags: bit0 address out of range, bit1 overrun
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no download; SoC running, host strobes ignored
// ACTIVE  | download open, buffer empty, waiting for a host byte
// WRITE   | buffer full, dn_wr asserted until the target accepts
// RELEASE | download closed, SoC held in reset for HOLD cycles

module ioctl_dn_ctrl #(
    parameter int ADDR_W = 14,
    parameter int HOLD   = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    input  logic              dn_ready,
    output logic [7:0]        dn_index,
    output logic              soc_reset,
    output logic [ADDR_W:0]   dn_count,
    output logic [1:0]        dn_err
);

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LOAD = HCW'(HOLD - 1);
    localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [HCW-1:0] hold_cnt;
    logic           addr_ok;
    logic           accept;
    logic           start;
    logic           capture;
    logic           drop_oor;
    logic           overrun;

    // Every address bit above the target window must be zero.
    assign addr_ok = ((ioctl_addr >> ADDR_W) == 25'd0);
    assign accept  = (state == WRITE) && dn_ready;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        capture    = 1'b0;
        drop_oor   = 1'b0;
        overrun    = 1'b0;
        case (state)
            IDLE: begin
                if (ioctl_download) begin
                    next_state = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                // A strobe in the same cycle the window closes is still
                // handled; the window close is acted on afterwards.
                if (ioctl_wr) begin
                    if (addr_ok) begin
                        capture    = 1'b1;
                        next_state = WRITE;
                    end else begin
                        drop_oor = 1'b1;
                    end
                end else if (!ioctl_download) begin
                    next_state = RELEASE;
                end
            end
            WRITE: begin
                overrun = ioctl_wr;
                if (dn_ready) begin
                    next_state = ioctl_download ? ACTIVE : RELEASE;
                end
            end
            RELEASE: begin
                if (ioctl_download) begin
                    next_state = ACTIVE;
                    start      = 1'b1;
                end else if (hold_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state, so they switch on the same edge
    // as the state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            soc_reset  <= 1'b1;
            dn_wr      <= 1'b0;
            ioctl_wait <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_index   <= '0;
            dn_count   <= '0;
            dn_err     <= '0;
            hold_cnt   <= '0;
        end else begin
            soc_reset  <= (next_state != IDLE);
            dn_wr      <= (next_state == WRITE);
            ioctl_wait <= (next_state == WRITE);

            if (capture) begin
                dn_addr <= ioctl_addr[ADDR_W-1:0];
                dn_data <= ioctl_dout;
            end

            if (start) begin
                dn_index <= ioctl_index;
                dn_count <= '0;
                dn_err   <= '0;
            end else begin
                if (accept && (dn_count != CNT_MAX)) begin
                    dn_count <= dn_count + CNT_ONE;
                end
                if (drop_oor) begin
                    dn_err[0] <= 1'b1;
                end
                if (overrun) begin
                    dn_err[1] <= 1'b1;
                end
            end

            // Loaded with HOLD-1 on entry, so RELEASE lasts exactly HOLD cycles.
            if ((next_state == RELEASE) && (state != RELEASE)) begin
                hold_cnt <= HOLD_LOAD;
            end else if ((state == RELEASE) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_ONE;
            end
        end
    end

endmodule

// File: doc/ioctl_dn_ctrl.md
IOCTL_DN_CTRL -- requirements
Module: ioctl_dn_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, width of the target address bus; valid range 1..24.
REQ-002 Parameter HOLD, default 16, number of clk_sys cycles soc_reset is held after a download ends; minimum 1.
REQ-003 clk_sys  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  host download window active.
REQ-006 ioctl_wr  in  1  single-cycle byte strobe from host.
REQ-007 ioctl_addr  in  25  host byte address.
REQ-008 ioctl_dout  in  8  host byte data.
REQ-009 ioctl_index  in  8  host file/target index.
REQ-010 ioctl_wait  out  1  registered back-pressure to host; high while the byte buffer is full.
REQ-011 dn_addr  out  ADDR_W  target write address.
REQ-012 dn_data  out  8  target write data.
REQ-013 dn_wr  out  1  target write request; held until accepted.
REQ-014 dn_ready  in  1  target accepts the write in any cycle where dn_wr and dn_ready are both high.
REQ-015 dn_index  out  8  index latched at download start.
REQ-016 soc_reset  out  1  reset to the SoC core.
REQ-017 dn_count  out  ADDR_W+1  bytes accepted by the target in the current/last download.
REQ-018 dn_err  out  2  sticky flags: bit0 address out of range, bit1 overrun.

Function
REQ-019 The block SHALL implement states IDLE, ACTIVE, WRITE, RELEASE.
REQ-020 IDLE: soc_reset = 0, ioctl_wait = 0, dn_wr = 0; ioctl_wr ignored.
REQ-021 IDLE -> ACTIVE on the first cycle ioctl_download = 1; same edge latches dn_index <= ioctl_index and clears dn_count and dn_err.
REQ-022 In ACTIVE, WRITE and RELEASE, soc_reset SHALL be 1.
REQ-023 ACTIVE, ioctl_wr = 1, ioctl_addr < 2**ADDR_W: capture addr[ADDR_W-1:0] and data into the buffer, set ioctl_wait next cycle, go to WRITE.
REQ-024 ACTIVE, ioctl_wr = 1, ioctl_addr >= 2**ADDR_W: discard the byte, set dn_err[0], stay in ACTIVE; dn_count unchanged.
REQ-025 WRITE: dn_wr = 1 with dn_addr/dn_data stable from the buffer until the acceptance cycle.
REQ-026 Acceptance cycle: next edge clears dn_wr and ioctl_wait, increments dn_count (saturating at 2**(ADDR_W+1)-1), returns to ACTIVE, or to RELEASE if ioctl_download = 0.
REQ-027 Minimum byte latency: ioctl_wr at cycle N -> dn_wr high from cycle N+1; with dn_ready tied high, ioctl_wait high only during cycle N+1.
REQ-028 ioctl_wr = 1 in WRITE SHALL set dn_err[1], drop the incoming byte and leave the buffered byte untouched.
REQ-029 ACTIVE with ioctl_download = 0 and no ioctl_wr in that cycle: go to RELEASE; simultaneous ioctl_wr is processed first per REQ-023/024.
REQ-030 ioctl_download falling while in WRITE: pending byte is completed before RELEASE; no byte is lost.
REQ-031 RELEASE: count HOLD cycles, then IDLE (soc_reset = 0 on the first IDLE cycle); ioctl_download rising during RELEASE restarts at ACTIVE per REQ-021.
REQ-032 ioctl_index changes after download start SHALL NOT affect dn_index.
REQ-033 dn_count, dn_err, dn_index SHALL hold their values in IDLE until the next download start.

Reset
REQ-034 While reset = 1: state = IDLE, soc_reset = 1, dn_wr = 0, ioctl_wait = 0, dn_addr = 0, dn_data = 0, dn_index = 0, dn_count = 0, dn_err = 0, hold counter = 0.
REQ-035 Reset mid-download SHALL drop any buffered byte without a dn_wr; after reset deasserts with ioctl_download still high, the next cycle enters ACTIVE per REQ-021.
REQ-036 First cycle after reset deasserts with ioctl_download = 0: soc_reset = 0.

Verification
REQ-037 dn_ready = 1, index 0x02, bytes 0xA5@0x0000, 0x5A@0x3FFF, download drop -> two dn_wr pulses with exact addr/data, dn_count = 2, dn_index = 0x02, soc_reset low exactly 16 cycles after RELEASE entry.
REQ-038 dn_ready low 5 cycles after capture -> dn_wr/ioctl_wait high 6 cycles, dn_addr/dn_data stable throughout, single count increment.
REQ-039 ioctl_addr = 0x4000 -> no dn_wr, dn_err = 2'b01, dn_count unchanged.
REQ-040 Second ioctl_wr while ioctl_wait high -> dn_err = 2'b10, only first byte written.
REQ-041 ioctl_download falls during WRITE with dn_ready low 3 cycles -> byte written, then RELEASE; soc_reset never deasserts early.
REQ-042 reset pulsed in WRITE -> dn_wr low next cycle, all outputs at REQ-034 values, no write of the buffered byte.
